// File: rtl/riscv_cpu_pkg.sv
// Shared CPU constants: reorder-buffer sizing, dependency tag sentinel,
// RoB entry type encodings and reservation-station opcode classes.
package riscv_cpu_pkg;

  localparam int RoB_WIDTH = 4;
  localparam int RoB_SIZE  = 1 << RoB_WIDTH;

  // One past the largest RoB index, so it can never alias a real tag.
  localparam logic [RoB_WIDTH:0] NON_DEP = (RoB_WIDTH + 1)'(RoB_SIZE);

  typedef enum logic [1:0] {
    ROB_REG    = 2'd0,
    ROB_BRANCH = 2'd1,
    ROB_STORE  = 2'd2,
    ROB_JALR   = 2'd3
  } rob_type_e;

  localparam logic [3:0] RS_OP_ADD  = 4'd0;
  localparam logic [3:0] RS_OP_SUB  = 4'd1;
  localparam logic [3:0] RS_OP_AND  = 4'd2;
  localparam logic [3:0] RS_OP_OR   = 4'd3;
  localparam logic [3:0] RS_OP_XOR  = 4'd4;
  localparam logic [3:0] RS_OP_SLL  = 4'd5;
  localparam logic [3:0] RS_OP_SRL  = 4'd6;
  localparam logic [3:0] RS_OP_SRA  = 4'd7;
  localparam logic [3:0] RS_OP_SLT  = 4'd8;
  localparam logic [3:0] RS_OP_SLTU = 4'd9;
  localparam logic [3:0] RS_OP_BR   = 4'd10;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at dispatch, collects ALU/LSB
// results, forwards operands, commits one entry per cycle and raises flush.
module reorder_buffer
  import riscv_cpu_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 alloc_en,
  input  logic [1:0]           alloc_type,
  input  logic [4:0]           alloc_rd,
  input  logic [31:0]          alloc_pc,
  input  logic                 alloc_pred_taken,
  input  logic [31:0]          alloc_alt_pc,
  output logic [RoB_WIDTH-1:0] alloc_index,
  input  logic [RoB_WIDTH-1:0] query_j_idx,
  input  logic [RoB_WIDTH-1:0] query_k_idx,
  output logic                 query_j_ready,
  output logic                 query_k_ready,
  output logic [31:0]          query_j_data,
  output logic [31:0]          query_k_data,
  input  logic                 alu_wb_en,
  input  logic [RoB_WIDTH-1:0] alu_wb_index,
  input  logic [31:0]          alu_wb_data,
  input  logic                 lsb_wb_en,
  input  logic [RoB_WIDTH-1:0] lsb_wb_index,
  input  logic [31:0]          lsb_wb_data,
  output logic                 commit_en,
  output logic [RoB_WIDTH-1:0] commit_index,
  output logic [4:0]           commit_rd,
  output logic [31:0]          commit_data,
  output logic                 commit_store,
  output logic                 flush_signal,
  output logic [31:0]          flush_pc,
  output logic                 isFull,
  output logic                 isEmpty
);

  localparam logic [RoB_WIDTH:0]   CNT_ONE  = (RoB_WIDTH + 1)'(1);
  localparam logic [RoB_WIDTH:0]   CNT_FULL = (RoB_WIDTH + 1)'(RoB_SIZE);
  localparam logic [RoB_WIDTH-1:0] PTR_ONE  = RoB_WIDTH'(1);

  logic [RoB_WIDTH-1:0] head, tail;
  logic [RoB_WIDTH:0]   count;
  logic [RoB_SIZE-1:0]  busy, ready, busy_nxt, ready_nxt;

  rob_type_e   ent_type [RoB_SIZE];
  logic [4:0]  ent_rd   [RoB_SIZE];
  logic [31:0] ent_pc   [RoB_SIZE];
  logic        ent_pred [RoB_SIZE];
  logic [31:0] ent_alt  [RoB_SIZE];
  logic [31:0] ent_data [RoB_SIZE];

  logic do_alloc, do_commit, head_flush, alu_hit, lsb_hit;

  assign isFull      = (count == CNT_FULL);
  assign isEmpty     = (count == '0);
  assign alloc_index = tail;
  assign alu_hit     = alu_wb_en && busy[alu_wb_index];
  assign lsb_hit     = lsb_wb_en && busy[lsb_wb_index];

  // flush_signal high means the buffer was just emptied, so nothing may enter or leave.
  assign do_alloc  = rdy_in && alloc_en && !isFull && !flush_signal;
  assign do_commit = rdy_in && !flush_signal && (count != '0) && busy[head] && ready[head];

  always_comb begin
    head_flush = 1'b0;
    case (ent_type[head])
      ROB_BRANCH: head_flush = (ent_data[head][0] != ent_pred[head]);
      ROB_JALR:   head_flush = 1'b1;
      default:    head_flush = 1'b0;
    endcase
  end

  always_comb begin
    busy_nxt  = busy;
    ready_nxt = ready;
    if (alu_hit) ready_nxt[alu_wb_index] = 1'b1;
    if (lsb_hit) ready_nxt[lsb_wb_index] = 1'b1;
    if (do_commit) begin
      busy_nxt[head]  = 1'b0;
      ready_nxt[head] = 1'b0;
    end
    if (do_alloc) begin
      busy_nxt[tail]  = 1'b1;
      ready_nxt[tail] = 1'b0;
    end
    if (do_commit && head_flush) begin
      busy_nxt  = '0;
      ready_nxt = '0;
    end
  end

  // Operand forwarding: a same-cycle writeback bypasses the entry, LSB taking priority.
  always_comb begin
    query_j_ready = ready[query_j_idx];
    query_j_data  = ent_data[query_j_idx];
    if (alu_wb_en && alu_wb_index == query_j_idx) begin
      query_j_ready = 1'b1;
      query_j_data  = alu_wb_data;
    end
    if (lsb_wb_en && lsb_wb_index == query_j_idx) begin
      query_j_ready = 1'b1;
      query_j_data  = lsb_wb_data;
    end
  end

  always_comb begin
    query_k_ready = ready[query_k_idx];
    query_k_data  = ent_data[query_k_idx];
    if (alu_wb_en && alu_wb_index == query_k_idx) begin
      query_k_ready = 1'b1;
      query_k_data  = alu_wb_data;
    end
    if (lsb_wb_en && lsb_wb_index == query_k_idx) begin
      query_k_ready = 1'b1;
      query_k_data  = lsb_wb_data;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      busy         <= '0;
      ready        <= '0;
      commit_en    <= 1'b0;
      commit_store <= 1'b0;
      flush_signal <= 1'b0;
      commit_index <= '0;
      commit_rd    <= '0;
      commit_data  <= '0;
      flush_pc     <= '0;
    end else if (!rdy_in) begin
      commit_en    <= 1'b0;
      commit_store <= 1'b0;
      flush_signal <= 1'b0;
    end else begin
      commit_en    <= do_commit;
      commit_store <= do_commit && (ent_type[head] == ROB_STORE);
      flush_signal <= do_commit && head_flush;
      busy         <= busy_nxt;
      ready        <= ready_nxt;
      if (do_commit) begin
        commit_index <= head;
        commit_rd    <= (ent_type[head] == ROB_REG || ent_type[head] == ROB_JALR) ? ent_rd[head] : 5'd0;
        commit_data  <= (ent_type[head] == ROB_JALR) ? ent_pc[head] + 32'd4 : ent_data[head];
        if (head_flush)
          flush_pc <= (ent_type[head] == ROB_JALR) ? ent_data[head] : ent_alt[head];
      end
      if (do_commit && head_flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_commit) head <= head + PTR_ONE;
        if (do_alloc)  tail <= tail + PTR_ONE;
        case ({do_alloc, do_commit})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

  // Entry payload carries no reset; busy/ready qualify every use of it.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (do_alloc) begin
        ent_type[tail] <= rob_type_e'(alloc_type);
        ent_rd[tail]   <= alloc_rd;
        ent_pc[tail]   <= alloc_pc;
        ent_pred[tail] <= alloc_pred_taken;
        ent_alt[tail]  <= alloc_alt_pc;
      end
      if (alu_hit) ent_data[alu_wb_index] <= alu_wb_data;
      if (lsb_hit) ent_data[lsb_wb_index] <= lsb_wb_data;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized
// traffic compared against an array-based behavioural model.
module tb_reorder_buffer;
  import riscv_cpu_pkg::*;

  logic clk_in = 1'b0, rst_in, rdy_in;
  logic alloc_en, alloc_pred_taken;
  logic [1:0] alloc_type;
  logic [4:0] alloc_rd;
  logic [31:0] alloc_pc, alloc_alt_pc;
  logic [3:0] alloc_index, query_j_idx, query_k_idx;
  logic query_j_ready, query_k_ready;
  logic [31:0] query_j_data, query_k_data;
  logic alu_wb_en, lsb_wb_en;
  logic [3:0] alu_wb_index, lsb_wb_index;
  logic [31:0] alu_wb_data, lsb_wb_data;
  logic commit_en, commit_store, flush_signal, isFull, isEmpty;
  logic [3:0] commit_index;
  logic [4:0] commit_rd;
  logic [31:0] commit_data, flush_pc;

  int n_tests = 0, n_fail = 0;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_en(alloc_en), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
    .alloc_pc(alloc_pc), .alloc_pred_taken(alloc_pred_taken), .alloc_alt_pc(alloc_alt_pc),
    .alloc_index(alloc_index),
    .query_j_idx(query_j_idx), .query_k_idx(query_k_idx),
    .query_j_ready(query_j_ready), .query_k_ready(query_k_ready),
    .query_j_data(query_j_data), .query_k_data(query_k_data),
    .alu_wb_en(alu_wb_en), .alu_wb_index(alu_wb_index), .alu_wb_data(alu_wb_data),
    .lsb_wb_en(lsb_wb_en), .lsb_wb_index(lsb_wb_index), .lsb_wb_data(lsb_wb_data),
    .commit_en(commit_en), .commit_index(commit_index), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_store(commit_store),
    .flush_signal(flush_signal), .flush_pc(flush_pc),
    .isFull(isFull), .isEmpty(isEmpty)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural model: a 16-slot circular array with head/tail/count integers.
  bit          m_busy [16], m_ready [16], m_pred [16];
  int          m_type [16];
  logic [4:0]  m_rd   [16];
  logic [31:0] m_pc   [16], m_alt [16], m_data [16];
  int          m_head, m_tail, m_count;
  bit          e_cen, e_cst, e_fl;
  int          e_cidx;
  logic [4:0]  e_crd;
  logic [31:0] e_cdata, e_fpc;

  task automatic model_reset();
    m_head = 0; m_tail = 0; m_count = 0;
    for (int i = 0; i < 16; i++) begin m_busy[i] = 0; m_ready[i] = 0; end
    e_cen = 0; e_cst = 0; e_fl = 0;
  endtask

  task automatic model_edge();
    int h;
    bit can, fl, alloc_ok;
    if (!rdy_in) begin e_cen = 0; e_cst = 0; e_fl = 0; return; end
    h = m_head;
    can = !e_fl && m_count > 0 && m_busy[h] && m_ready[h];
    fl = 0;
    if (can) begin
      e_cidx = h;
      e_cdata = m_data[h];
      e_crd = 5'd0;
      case (m_type[h])
        0: e_crd = m_rd[h];
        1: begin fl = (m_data[h][0] != m_pred[h]); e_fpc = m_alt[h]; end
        3: begin e_crd = m_rd[h]; e_cdata = m_pc[h] + 32'd4; fl = 1; e_fpc = m_data[h]; end
        default: ;
      endcase
    end
    alloc_ok = alloc_en && m_count < 16 && !e_fl;
    e_cen = can; e_cst = can && m_type[h] == 2; e_fl = fl;
    if (fl) begin
      m_head = 0; m_tail = 0; m_count = 0;
      for (int i = 0; i < 16; i++) begin m_busy[i] = 0; m_ready[i] = 0; end
      return;
    end
    if (alu_wb_en && m_busy[alu_wb_index]) begin m_data[alu_wb_index] = alu_wb_data; m_ready[alu_wb_index] = 1; end
    if (lsb_wb_en && m_busy[lsb_wb_index]) begin m_data[lsb_wb_index] = lsb_wb_data; m_ready[lsb_wb_index] = 1; end
    if (can) begin m_busy[h] = 0; m_ready[h] = 0; m_head = (h + 1) % 16; m_count--; end
    if (alloc_ok) begin
      m_busy[m_tail] = 1; m_ready[m_tail] = 0; m_type[m_tail] = int'(alloc_type);
      m_rd[m_tail] = alloc_rd; m_pc[m_tail] = alloc_pc; m_pred[m_tail] = alloc_pred_taken;
      m_alt[m_tail] = alloc_alt_pc; m_tail = (m_tail + 1) % 16; m_count++;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_in);
    #1;
    alloc_en = 0; alu_wb_en = 0; lsb_wb_en = 0;
  endtask

  task automatic do_reset();
    rst_in = 1; rdy_in = 1; alloc_en = 0; alu_wb_en = 0; lsb_wb_en = 0;
    @(posedge clk_in); #1;
    rst_in = 0;
    model_reset();
  endtask

  task automatic set_alloc(input int t, input int rd, input int pc, input bit pred, input int alt);
    alloc_en = 1; alloc_type = 2'(t); alloc_rd = 5'(rd); alloc_pc = 32'(pc);
    alloc_pred_taken = pred; alloc_alt_pc = 32'(alt);
  endtask

  task automatic test_reset();
    rst_in = 1;
    @(posedge clk_in); @(posedge clk_in); #1;
    n_tests++; if ({commit_en, commit_store, flush_signal} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses got %b want 000", {commit_en, commit_store, flush_signal}); end
    n_tests++; if ({commit_index, commit_rd, commit_data, flush_pc} !== '0) begin n_fail++; $display("FAIL reset_regs got %h/%h/%h/%h want 0", commit_index, commit_rd, commit_data, flush_pc); end
    n_tests++; if ({isEmpty, isFull, alloc_index} !== 6'b10_0000) begin n_fail++; $display("FAIL reset_flags got %b want 100000", {isEmpty, isFull, alloc_index}); end
    rst_in = 0;
    model_reset();
  endtask

  task automatic test_in_order();
    do_reset();
    for (int i = 0; i < 3; i++) begin set_alloc(0, i + 1, 4 * i, 0, 0); step(); end
    n_tests++; if (alloc_index !== 4'd3 || isEmpty !== 1'b0) begin n_fail++; $display("FAIL inorder_alloc got idx %0d empty %b want 3 0", alloc_index, isEmpty); end
    alu_wb_en = 1; alu_wb_index = 2; alu_wb_data = 32'h22; step();
    n_tests++; if (commit_en !== 1'b0) begin n_fail++; $display("FAIL inorder_early_commit got %b want 0", commit_en); end
    alu_wb_en = 1; alu_wb_index = 0; alu_wb_data = 32'h00;
    lsb_wb_en = 1; lsb_wb_index = 1; lsb_wb_data = 32'h11; step();
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (commit_en !== 1'b1 || commit_index !== 4'(i) || commit_rd !== 5'(i + 1) || commit_data !== 32'h11 * i) begin
        n_fail++; $display("FAIL inorder_commit%0d got en %b idx %0d rd %0d data %h want 1 %0d %0d %h", i, commit_en, commit_index, commit_rd, commit_data, i, i + 1, 32'h11 * i);
      end
    end
    step();
    n_tests++; if (commit_en !== 1'b0 || isEmpty !== 1'b1) begin n_fail++; $display("FAIL inorder_drain got en %b empty %b want 0 1", commit_en, isEmpty); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin set_alloc(0, i, 0, 0, 0); step(); end
    n_tests++; if (isFull !== 1'b1 || alloc_index !== 4'd0) begin n_fail++; $display("FAIL full_set got full %b idx %0d want 1 0", isFull, alloc_index); end
    set_alloc(0, 9, 0, 0, 0); step();
    n_tests++; if (isFull !== 1'b1 || alloc_index !== 4'd0) begin n_fail++; $display("FAIL full_ignore got full %b idx %0d want 1 0", isFull, alloc_index); end
    alu_wb_en = 1; alu_wb_index = 0; alu_wb_data = 32'h5;
    lsb_wb_en = 1; lsb_wb_index = 1; lsb_wb_data = 32'h6; step();
    set_alloc(0, 9, 0, 0, 0); step();
    n_tests++; if (commit_en !== 1'b1 || commit_index !== 4'd0 || isFull !== 1'b0 || alloc_index !== 4'd0) begin n_fail++; $display("FAIL full_commit got en %b idx %0d full %b tail %0d want 1 0 0 0", commit_en, commit_index, isFull, alloc_index); end
    set_alloc(0, 9, 0, 0, 0); step();
    n_tests++; if (commit_en !== 1'b1 || commit_index !== 4'd1 || isFull !== 1'b0 || alloc_index !== 4'd1) begin n_fail++; $display("FAIL full_alloc_commit got en %b idx %0d full %b tail %0d want 1 1 0 1", commit_en, commit_index, isFull, alloc_index); end
  endtask

  task automatic test_branch();
    do_reset();
    set_alloc(1, 7, 32'h20, 0, 32'h100); step();
    alu_wb_en = 1; alu_wb_index = 0; alu_wb_data = 32'h1; step();
    set_alloc(0, 3, 0, 0, 0); step();
    n_tests++; if (commit_en !== 1'b1 || flush_signal !== 1'b1 || flush_pc !== 32'h100 || commit_rd !== 5'd0) begin n_fail++; $display("FAIL branch_mispredict got en %b fl %b pc %h rd %0d want 1 1 100 0", commit_en, flush_signal, flush_pc, commit_rd); end
    n_tests++; if (isEmpty !== 1'b1 || alloc_index !== 4'd0) begin n_fail++; $display("FAIL branch_flush_drop got empty %b idx %0d want 1 0", isEmpty, alloc_index); end
    set_alloc(0, 3, 0, 0, 0); step();
    n_tests++; if (isEmpty !== 1'b1 || alloc_index !== 4'd0 || flush_signal !== 1'b0 || commit_en !== 1'b0) begin n_fail++; $display("FAIL branch_after_flush got empty %b idx %0d fl %b en %b want 1 0 0 0", isEmpty, alloc_index, flush_signal, commit_en); end
    set_alloc(1, 7, 32'h30, 1, 32'h200); step();
    lsb_wb_en = 1; lsb_wb_index = 0; lsb_wb_data = 32'h1; step();
    step();
    n_tests++; if (commit_en !== 1'b1 || flush_signal !== 1'b0 || commit_index !== 4'd0) begin n_fail++; $display("FAIL branch_correct got en %b fl %b idx %0d want 1 0 0", commit_en, flush_signal, commit_index); end
  endtask

  task automatic test_jalr();
    do_reset();
    set_alloc(3, 1, 32'h40, 0, 0); step();
    alu_wb_en = 1; alu_wb_index = 0; alu_wb_data = 32'h80; step();
    step();
    n_tests++; if (commit_en !== 1'b1 || commit_rd !== 5'd1 || commit_data !== 32'h44 || flush_signal !== 1'b1 || flush_pc !== 32'h80) begin n_fail++; $display("FAIL jalr got en %b rd %0d data %h fl %b pc %h want 1 1 44 1 80", commit_en, commit_rd, commit_data, flush_signal, flush_pc); end
  endtask

  task automatic test_store();
    do_reset();
    set_alloc(2, 9, 32'h50, 0, 0); step();
    lsb_wb_en = 1; lsb_wb_index = 0; lsb_wb_data = 32'h0; step();
    step();
    n_tests++; if (commit_en !== 1'b1 || commit_store !== 1'b1 || commit_rd !== 5'd0 || flush_signal !== 1'b0) begin n_fail++; $display("FAIL store got en %b st %b rd %0d fl %b want 1 1 0 0", commit_en, commit_store, commit_rd, flush_signal); end
  endtask

  task automatic test_bypass();
    do_reset();
    for (int i = 0; i < 5; i++) begin set_alloc(0, i + 1, 0, 0, 0); step(); end
    for (int i = 0; i < 5; i++) begin alu_wb_en = 1; alu_wb_index = 4'(i); alu_wb_data = 32'(i); step(); end
    for (int i = 0; i < 3; i++) step();
    n_tests++; if (isEmpty !== 1'b1 || alloc_index !== 4'd5) begin n_fail++; $display("FAIL bypass_setup got empty %b idx %0d want 1 5", isEmpty, alloc_index); end
    set_alloc(0, 7, 0, 0, 0); step();
    query_j_idx = 5; #1;
    n_tests++; if (query_j_ready !== 1'b0) begin n_fail++; $display("FAIL bypass_not_ready got %b want 0", query_j_ready); end
    alu_wb_en = 1; alu_wb_index = 5; alu_wb_data = 32'hABCD; #1;
    n_tests++; if (query_j_ready !== 1'b1 || query_j_data !== 32'hABCD) begin n_fail++; $display("FAIL bypass_query got %b %h want 1 abcd", query_j_ready, query_j_data); end
    step();
    n_tests++; if (commit_en !== 1'b0) begin n_fail++; $display("FAIL bypass_early_commit got %b want 0", commit_en); end
    step();
    n_tests++; if (commit_en !== 1'b1 || commit_index !== 4'd5 || commit_data !== 32'hABCD || commit_rd !== 5'd7) begin n_fail++; $display("FAIL bypass_commit got en %b idx %0d data %h rd %0d want 1 5 abcd 7", commit_en, commit_index, commit_data, commit_rd); end
  endtask

  task automatic test_pause();
    do_reset();
    for (int i = 0; i < 2; i++) begin set_alloc(0, 4, 0, 0, 0); step(); end
    alu_wb_en = 1; alu_wb_index = 0; alu_wb_data = 32'h77; step();
    rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      set_alloc(0, 4, 0, 0, 0); step();
      n_tests++; if (commit_en !== 1'b0 || alloc_index !== 4'd2) begin n_fail++; $display("FAIL pause_hold%0d got en %b idx %0d want 0 2", i, commit_en, alloc_index); end
    end
    rdy_in = 1; step();
    n_tests++; if (commit_en !== 1'b1 || commit_index !== 4'd0 || commit_data !== 32'h77) begin n_fail++; $display("FAIL pause_resume got en %b idx %0d data %h want 1 0 77", commit_en, commit_index, commit_data); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin set_alloc(0, 2, 0, 0, 0); step(); end
    alu_wb_en = 1; alu_wb_index = 0; alu_wb_data = 32'h99; step();
    step();
    n_tests++; if (commit_en !== 1'b1 || isEmpty !== 1'b0) begin n_fail++; $display("FAIL areset_pre got en %b empty %b want 1 0", commit_en, isEmpty); end
    #2 rst_in = 1; #1;
    n_tests++; if ({commit_en, commit_store, flush_signal, isFull} !== 4'b0000 || isEmpty !== 1'b1 || alloc_index !== 4'd0) begin n_fail++; $display("FAIL areset_flags got %b empty %b idx %0d want 0000 1 0", {commit_en, commit_store, flush_signal, isFull}, isEmpty, alloc_index); end
    n_tests++; if ({commit_index, commit_rd, commit_data, flush_pc} !== '0) begin n_fail++; $display("FAIL areset_regs got %h/%h/%h/%h want 0", commit_index, commit_rd, commit_data, flush_pc); end
    @(posedge clk_in); #1;
    rst_in = 0;
    model_reset();
  endtask

  task automatic test_random();
    bit ej, ek;
    logic [31:0] dj, dk;
    int r;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rdy_in = ($urandom_range(9) != 0);
      alloc_en = ($urandom_range(9) < 6);
      r = $urandom_range(99);
      alloc_type = (r < 50) ? 2'd0 : (r < 78) ? 2'd1 : (r < 94) ? 2'd2 : 2'd3;
      alloc_rd = 5'($urandom); alloc_pc = {$urandom} & 32'hFFFF_FFFC;
      alloc_pred_taken = 1'($urandom); alloc_alt_pc = $urandom;
      alu_wb_en = ($urandom_range(1) == 1); alu_wb_index = 4'(m_head + $urandom_range(5)); alu_wb_data = $urandom;
      lsb_wb_en = ($urandom_range(9) < 4);  lsb_wb_index = 4'(m_head + $urandom_range(5)); lsb_wb_data = $urandom;
      query_j_idx = 4'($urandom); query_k_idx = 4'(m_head + $urandom_range(3));
      #1;
      ej = m_ready[query_j_idx]; dj = m_data[query_j_idx];
      if (alu_wb_en && alu_wb_index == query_j_idx) begin ej = 1; dj = alu_wb_data; end
      if (lsb_wb_en && lsb_wb_index == query_j_idx) begin ej = 1; dj = lsb_wb_data; end
      ek = m_ready[query_k_idx]; dk = m_data[query_k_idx];
      if (alu_wb_en && alu_wb_index == query_k_idx) begin ek = 1; dk = alu_wb_data; end
      if (lsb_wb_en && lsb_wb_index == query_k_idx) begin ek = 1; dk = lsb_wb_data; end
      n_tests++; if (query_j_ready !== ej || (ej && query_j_data !== dj)) begin n_fail++; $display("FAIL rand_query_j c%0d got %b %h want %b %h", c, query_j_ready, query_j_data, ej, dj); end
      n_tests++; if (query_k_ready !== ek || (ek && query_k_data !== dk)) begin n_fail++; $display("FAIL rand_query_k c%0d got %b %h want %b %h", c, query_k_ready, query_k_data, ek, dk); end
      step();
      n_tests++; if (commit_en !== e_cen || flush_signal !== e_fl || commit_store !== e_cst) begin n_fail++; $display("FAIL rand_pulses c%0d got %b%b%b want %b%b%b", c, commit_en, flush_signal, commit_store, e_cen, e_fl, e_cst); end
      n_tests++; if (alloc_index !== 4'(m_tail) || isFull !== (m_count == 16) || isEmpty !== (m_count == 0)) begin n_fail++; $display("FAIL rand_ptrs c%0d got tail %0d full %b empty %b want %0d cnt %0d", c, alloc_index, isFull, isEmpty, m_tail, m_count); end
      if (e_cen) begin
        n_tests++; if (commit_index !== 4'(e_cidx) || commit_rd !== e_crd || commit_data !== e_cdata) begin n_fail++; $display("FAIL rand_commit c%0d got %0d %0d %h want %0d %0d %h", c, commit_index, commit_rd, commit_data, e_cidx, e_crd, e_cdata); end
      end
      if (e_fl) begin
        n_tests++; if (flush_pc !== e_fpc) begin n_fail++; $display("FAIL rand_flush_pc c%0d got %h want %h", c, flush_pc, e_fpc); end
      end
    end
    rdy_in = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1; rdy_in = 1; alloc_en = 0; alloc_type = 0; alloc_rd = 0; alloc_pc = 0;
    alloc_pred_taken = 0; alloc_alt_pc = 0; query_j_idx = 0; query_k_idx = 0;
    alu_wb_en = 0; alu_wb_index = 0; alu_wb_data = 0;
    lsb_wb_en = 0; lsb_wb_index = 0; lsb_wb_data = 0;
    test_reset();
    test_in_order();
    test_full_wrap();
    test_branch();
    test_jalr();
    test_store();
    test_bypass();
    test_pause();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
